// File: rtl/ofifo_pkg.sv
// Shared types and width helpers for the deskewing, compressing output FIFO.
package ofifo_pkg;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  // Main word: one flag bit plus the low CBW bits of every column.
  function automatic int mainWidth(input int col, input int cbw);
    return col * cbw + 1;
  endfunction

  // Aux word: the high psum_bw-CBW bits of every column.
  function automatic int auxWidth(input int col, input int psumBw, input int cbw);
    return col * (psumBw - cbw);
  endfunction

  // Pointer width for a power-of-two FIFO depth.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ofifo_sfifo.sv
// Generic synchronous FIFO with a combinational head (first-word fall-through read).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module ofifo_sfifo
  import ofifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = ptrWidth(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/ofifo_deskew_comp.sv
// Output FIFO: per-column lanes realign skewed psum writes into rows, rows are stored
// as a compressed main word plus an optional aux word, and a registered output stage
// rebuilds full-width rows under a valid/read handshake.
module ofifo_deskew_comp
  import ofifo_pkg::*;
#(
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int CBW        = 9,
  parameter int LANE_DEPTH = 4,
  parameter int DEPTH      = 64,
  parameter int AUX_DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [col-1:0]           wr,
  input  logic [col*psum_bw-1:0]   in,
  input  logic                     comp_en,
  input  logic                     rd,
  input  logic                     clr_cnt,
  output logic [col*psum_bw-1:0]   out,
  output logic                     o_valid,
  output logic                     o_ready,
  output logic                     o_full,
  output logic                     o_ovf,
  output logic [15:0]              o_raw_cnt
);

  localparam int MAIN_W = mainWidth(col, CBW);
  localparam int AUX_W  = auxWidth(col, psum_bw, CBW);
  localparam int HI_W   = psum_bw - CBW;
  localparam int LCW    = $clog2(LANE_DEPTH) + 1;

  logic [col-1:0]          laneFull;
  logic [col-1:0]          laneEmpty;
  logic [psum_bw-1:0]      laneHead [col];
  logic [LCW-1:0]          laneCount [col];
  logic                    assemble;
  logic                    rowFlag;
  logic [MAIN_W-1:0]       mainWord;
  logic [AUX_W-1:0]        auxWord;
  logic                    mainFull;
  logic                    mainEmpty;
  logic [MAIN_W-1:0]       mainHead;
  logic                    mainPop;
  logic                    auxFull;
  logic                    auxEmpty;
  logic [AUX_W-1:0]        auxHead;
  logic                    auxPush;
  logic                    auxPop;
  logic [$clog2(DEPTH):0]     unusedMainCount;
  logic [$clog2(AUX_DEPTH):0] unusedAuxCount;
  logic [col*psum_bw-1:0]  out_d;
  logic                    allLanesFree;
  out_state_e              state_q;
  logic [col*psum_bw-1:0]  out_q;
  logic                    ovf_q;
  logic [15:0]             rawCnt_q;

  for (genvar g = 0; g < col; g++) begin : gLane
    ofifo_sfifo #(.WIDTH(psum_bw), .DEPTH(LANE_DEPTH)) uLane (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (wr[g]),
      .pop_i   (assemble),
      .wdata_i (in[g*psum_bw +: psum_bw]),
      .rdata_o (laneHead[g]),
      .full_o  (laneFull[g]),
      .empty_o (laneEmpty[g]),
      .count_o (laneCount[g])
    );
  end

  // The aux-full check is unconditional so assembly never depends on compressibility.
  assign assemble = !(|laneEmpty) && !mainFull && !auxFull;
  assign auxPush  = assemble && !rowFlag;

  // Split the lane heads into the main word (flag + low bits) and the aux word (high bits).
  always_comb begin
    rowFlag  = comp_en;
    mainWord = '0;
    auxWord  = '0;
    for (int c = 0; c < col; c++) begin
      if (!(&laneHead[c][psum_bw-1:CBW-1]) && (|laneHead[c][psum_bw-1:CBW-1])) rowFlag = 1'b0;
      mainWord[c*CBW +: CBW]  = laneHead[c][CBW-1:0];
      auxWord[c*HI_W +: HI_W] = laneHead[c][psum_bw-1:CBW];
    end
    mainWord[MAIN_W-1] = rowFlag;
  end

  ofifo_sfifo #(.WIDTH(MAIN_W), .DEPTH(DEPTH)) uMain (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (assemble),
    .pop_i   (mainPop),
    .wdata_i (mainWord),
    .rdata_o (mainHead),
    .full_o  (mainFull),
    .empty_o (mainEmpty),
    .count_o (unusedMainCount)
  );

  ofifo_sfifo #(.WIDTH(AUX_W), .DEPTH(AUX_DEPTH)) uAux (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (auxPush),
    .pop_i   (auxPop),
    .wdata_i (auxWord),
    .rdata_o (auxHead),
    .full_o  (auxFull),
    .empty_o (auxEmpty),
    .count_o (unusedAuxCount)
  );

  // Main and aux are consumed in lockstep, so the aux head always belongs to a flag=0 main head.
  assign mainPop = !mainEmpty && ((state_q == OUT_EMPTY) || rd);
  assign auxPop  = mainPop && !mainHead[MAIN_W-1] && !auxEmpty;

  // Rebuild the full-width row: sign-extend compressed columns, otherwise splice in aux bits.
  always_comb begin
    out_d = '0;
    for (int c = 0; c < col; c++) begin
      if (mainHead[MAIN_W-1])
        out_d[c*psum_bw +: psum_bw] = {{HI_W{mainHead[c*CBW+CBW-1]}}, mainHead[c*CBW +: CBW]};
      else
        out_d[c*psum_bw +: psum_bw] = {auxHead[c*HI_W +: HI_W], mainHead[c*CBW +: CBW]};
    end
  end

  // Ready only while every lane can take one more write.
  always_comb begin
    allLanesFree = 1'b1;
    for (int c = 0; c < col; c++) begin
      if (laneCount[c] == LCW'(LANE_DEPTH)) allLanesFree = 1'b0;
    end
  end

  // Output stage FSM: load on empty, reload or drain on read, hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= OUT_EMPTY;
      out_q   <= '0;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (!mainEmpty) begin
            state_q <= OUT_VALID;
            out_q   <= out_d;
          end
        end
        OUT_VALID: begin
          if (rd) begin
            if (!mainEmpty) out_q   <= out_d;
            else            state_q <= OUT_EMPTY;
          end
        end
        default: state_q <= OUT_EMPTY;
      endcase
    end
  end

  // Sticky overflow on a dropped lane write, and the saturating raw-row counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q    <= 1'b0;
      rawCnt_q <= '0;
    end else begin
      if (|(wr & laneFull & ~{col{assemble}})) ovf_q <= 1'b1;
      if (clr_cnt)
        rawCnt_q <= '0;
      else if (auxPush && (rawCnt_q != 16'hFFFF))
        rawCnt_q <= rawCnt_q + 16'd1;
    end
  end

  assign out       = out_q;
  assign o_valid   = (state_q == OUT_VALID);
  assign o_ready   = allLanesFree;
  assign o_full    = !allLanesFree;
  assign o_ovf     = ovf_q;
  assign o_raw_cnt = rawCnt_q;

endmodule

// File: tb/tb_ofifo_deskew_comp.sv
// Self-checking bench for ofifo_deskew_comp: a scoreboard queue holds every row in
// drive order and a negedge monitor compares each row handed out on a read.
module tb_ofifo_deskew_comp;

  localparam int COL        = 8;
  localparam int PBW        = 16;
  localparam int CBW        = 9;
  localparam int LANE_DEPTH = 4;
  localparam int DEPTH      = 64;
  localparam int AUX_DEPTH  = 32;
  localparam int ROW_W      = COL * PBW;
  // Rows absorbed before lanes fill when nothing is read: the output stage holds one,
  // aux limits main+aux to AUX_DEPTH more, and each lane then holds LANE_DEPTH.
  localparam int AUX_CAP    = 1 + AUX_DEPTH + LANE_DEPTH;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [COL-1:0]   wrMask = '0;
  logic [ROW_W-1:0] inData = '0;
  logic             compEn = 1'b1;
  logic             rdEn = 1'b0;
  logic             clrCnt = 1'b0;
  logic [ROW_W-1:0] outRow;
  logic             oValid;
  logic             oReady;
  logic             oFull;
  logic             oOvf;
  logic [15:0]      oRawCnt;

  int total = 0;
  int bad = 0;
  logic [ROW_W-1:0] sb [$];

  typedef struct {
    logic [ROW_W-1:0] row;
    logic             compEn;
    logic             expRaw;
  } vec_t;
  vec_t vecs [12];

  ofifo_deskew_comp #(
    .col(COL), .psum_bw(PBW), .CBW(CBW),
    .LANE_DEPTH(LANE_DEPTH), .DEPTH(DEPTH), .AUX_DEPTH(AUX_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wrMask),
    .in        (inData),
    .comp_en   (compEn),
    .rd        (rdEn),
    .clr_cnt   (clrCnt),
    .out       (outRow),
    .o_valid   (oValid),
    .o_ready   (oReady),
    .o_full    (oFull),
    .o_ovf     (oOvf),
    .o_raw_cnt (oRawCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [ROW_W-1:0] actual,
                             input logic [ROW_W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Every row handed out on a read must be the oldest row still expected.
  always @(negedge clk) begin
    if (reset && oValid && rdEn) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedRow: got %h expected none", outRow);
      end else begin
        checkOutput("rowData", outRow, sb.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [COL-1:0] mask, input logic [ROW_W-1:0] row,
                               input logic ce);
    wrMask = mask;
    inData = row;
    compEn = ce;
    @(posedge clk);
    #1;
    wrMask = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    sb.delete();
    idle(2);
    reset = 1'b1;
    idle(1);
  endtask

  task automatic drainAll(input string name);
    int guard = 0;
    rdEn = 1'b1;
    while (sb.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    rdEn = 1'b0;
    checkOutput({name, "Drained"}, ROW_W'(sb.size()), '0);
    idle(2);
    checkOutput({name, "IdleValid"}, oValid, 1'b0);
  endtask

  // Compressible row: small magnitudes, negated on odd rows.
  function automatic logic [ROW_W-1:0] compRow(input int i);
    logic [ROW_W-1:0] r;
    int v;
    r = '0;
    for (int c = 0; c < COL; c++) begin
      v = (i * COL + c) % 256;
      if (i % 2 == 1) v = -v;
      r[c*PBW +: PBW] = 16'(v);
    end
    return r;
  endfunction

  // Uncompressible row: bit 14 set forces the high bits to be mixed.
  function automatic logic [ROW_W-1:0] rawRow(input int i);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = 16'h4000 | 16'(i << 4) | 16'(c);
    return r;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [ROW_W-1:0] r;
    logic [ROW_W-1:0] skewRow;
    logic [COL-1:0]   mask;
    int expRaw;

    // Reset values while reset is held low.
    idle(3);
    checkOutput("resetOut", outRow, '0);
    checkOutput("resetValid", oValid, 1'b0);
    checkOutput("resetReady", oReady, 1'b1);
    checkOutput("resetFull", oFull, 1'b0);
    checkOutput("resetOvf", oOvf, 1'b0);
    checkOutput("resetRaw", oRawCnt, 16'd0);
    reset = 1'b1;
    idle(1);

    // Latency: a row written at edge t is on out at edge t+2.
    r = compRow(3);
    sb.push_back(r);
    applyStimulus('1, r, 1'b1);
    idle(1);
    checkOutput("latencyT1", oValid, 1'b0);
    idle(1);
    checkOutput("latencyT2", oValid, 1'b1);
    checkOutput("latencyOut", outRow, r);
    drainAll("latency");

    // Skewed compressible rows: column c starts c cycles late.
    for (int c = 0; c < COL; c++) skewRow[c*PBW +: PBW] = 16'(c - 3);
    for (int k = 0; k < 4 + COL - 1; k++) begin
      for (int c = 0; c < COL; c++) mask[c] = (k - c >= 0) && (k - c < 4);
      if (k < 4) sb.push_back(skewRow);
      applyStimulus(mask, skewRow, 1'b1);
    end
    drainAll("skew");
    checkOutput("skewRaw", oRawCnt, 16'd0);

    // Table of rows: exact reconstruction and whether each row goes through aux.
    r = {COL{16'h0001}}; r[15:0] = 16'h7FFF;
    vecs[0]  = '{row: r, compEn: 1'b1, expRaw: 1'b1};
    vecs[1]  = '{row: {COL{16'hFFF0}}, compEn: 1'b1, expRaw: 1'b0};
    r = '0; r[5*PBW +: PBW] = 16'h8000;
    vecs[2]  = '{row: r, compEn: 1'b1, expRaw: 1'b1};
    vecs[3]  = '{row: {COL{16'h00FF}}, compEn: 1'b1, expRaw: 1'b0};
    vecs[4]  = '{row: {COL{16'h0100}}, compEn: 1'b1, expRaw: 1'b1};
    vecs[5]  = '{row: {COL{16'hFF00}}, compEn: 1'b1, expRaw: 1'b0};
    vecs[6]  = '{row: {COL{16'hFEFF}}, compEn: 1'b1, expRaw: 1'b1};
    vecs[7]  = '{row: {(COL/2){16'hFF00, 16'h00FF}}, compEn: 1'b1, expRaw: 1'b0};
    vecs[8]  = '{row: '0, compEn: 1'b0, expRaw: 1'b1};
    vecs[9]  = '{row: '0, compEn: 1'b0, expRaw: 1'b1};
    vecs[10] = '{row: '0, compEn: 1'b0, expRaw: 1'b1};
    vecs[11] = '{row: {COL{16'hFFF0}}, compEn: 1'b0, expRaw: 1'b1};
    clrCnt = 1'b1;
    idle(1);
    clrCnt = 1'b0;
    expRaw = 0;
    rdEn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sb.push_back(vecs[i].row);
      applyStimulus('1, vecs[i].row, vecs[i].compEn);
      idle(2);
      if (vecs[i].expRaw) expRaw++;
      checkOutput("tableRawCnt", oRawCnt, 16'(expRaw));
    end
    drainAll("table");
    compEn = 1'b1;

    // Clear wins over an increment in the same cycle.
    clrCnt = 1'b1;
    idle(1);
    clrCnt = 1'b0;
    r = rawRow(1);
    sb.push_back(r);
    applyStimulus('1, r, 1'b1);
    clrCnt = 1'b1;
    idle(1);
    clrCnt = 1'b0;
    checkOutput("clrPriority", oRawCnt, 16'd0);
    drainAll("clr");

    // Aux backpressure with no reads, then one dropped write.
    doReset();
    for (int i = 1; i <= AUX_CAP; i++) begin
      r = rawRow(i);
      sb.push_back(r);
      applyStimulus('1, r, 1'b1);
      if (i == AUX_CAP - 1) checkOutput("auxReadyBeforeCap", oReady, 1'b1);
    end
    checkOutput("auxReadyAtCap", oReady, 1'b0);
    checkOutput("auxFullAtCap", oFull, 1'b1);
    checkOutput("auxOvfBeforeDrop", oOvf, 1'b0);
    applyStimulus('1, rawRow(99), 1'b1);
    checkOutput("auxOvfAfterDrop", oOvf, 1'b1);
    drainAll("aux");
    checkOutput("auxOvfSticky", oOvf, 1'b1);
    checkOutput("auxRawCnt", oRawCnt, 16'(AUX_CAP));

    // Main full, then read one row per cycle while new rows keep arriving.
    doReset();
    for (int i = 0; i <= DEPTH; i++) begin
      r = compRow(i);
      sb.push_back(r);
      applyStimulus('1, r, 1'b1);
    end
    idle(3);
    rdEn = 1'b1;
    for (int i = DEPTH + 1; i < DEPTH + 31; i++) begin
      r = compRow(i);
      sb.push_back(r);
      applyStimulus('1, r, 1'b1);
      checkOutput("streamValid", oValid, 1'b1);
    end
    drainAll("stream");
    checkOutput("streamOvf", oOvf, 1'b0);

    // Reset with rows buffered: outputs clear at once, old rows never return.
    doReset();
    for (int i = 0; i < 10; i++) begin
      r = rawRow(i + 100);
      sb.push_back(r);
      applyStimulus('1, r, 1'b1);
    end
    idle(3);
    reset = 1'b0;
    #1;
    checkOutput("midResetOut", outRow, '0);
    checkOutput("midResetValid", oValid, 1'b0);
    checkOutput("midResetReady", oReady, 1'b1);
    checkOutput("midResetFull", oFull, 1'b0);
    checkOutput("midResetRaw", oRawCnt, 16'd0);
    sb.delete();
    idle(2);
    reset = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      r = compRow(i + 20);
      sb.push_back(r);
      applyStimulus('1, r, 1'b1);
    end
    drainAll("postReset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
